rd_side_ctrl_sync: RTL and testbench

Parametrised read-domain controller for the dual-clock FIFO. It is the next generation of the read-pointer/empty block. It adds:
- an internal multi-stage synchroniser for the incoming write gray pointer,
- a full-range used-word count (0..2**AWIDTH inclusive),
- an almost-empty flag with programmable level,
- an underflow pulse,
- a selectable normal/show-ahead RAM read-address mode.

It sits between the FIFO RAM read port and the write-side controller, which consumes rd_pntr_gray_o.

---
 rtl/rd_side_ctrl_sync_if.sv | 39 +++
 rtl/rd_side_ctrl_sync.sv | 116 +++++++++++
 tb/tb_rd_side_ctrl_sync.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rd_side_ctrl_sync_if.sv
// Read-side FIFO controller bus: user read handshake, the incoming write gray
// pointer, and the read-domain status/address outputs.
//   slave  : the controller (rd_side_ctrl_sync)
//   master : the FIFO user / write-side environment
// Signals:
//   rd_req_i           read request from the FIFO user
//   wr_pntr_gray_i     write pointer, gray code, unsynchronised
//   rd_ack_o           combinational read accept
//   rd_addr_o          RAM read address
//   rd_pntr_gray_o     registered read pointer, gray code
//   rd_empty_o         registered empty flag
//   rd_almost_empty_o  registered almost-empty flag
//   rd_usedw_o         registered used-word count, 0..2**AWIDTH
//   rd_underflow_o     one-cycle pulse for a read request while empty
interface rd_side_ctrl_sync_if #(
  parameter int unsigned AWIDTH = 3
);
  logic              rd_req_i;
  logic [AWIDTH:0]   wr_pntr_gray_i;
  logic              rd_ack_o;
  logic [AWIDTH-1:0] rd_addr_o;
  logic [AWIDTH:0]   rd_pntr_gray_o;
  logic              rd_empty_o;
  logic              rd_almost_empty_o;
  logic [AWIDTH:0]   rd_usedw_o;
  logic              rd_underflow_o;

  modport slave (
    input  rd_req_i, wr_pntr_gray_i,
    output rd_ack_o, rd_addr_o, rd_pntr_gray_o, rd_empty_o,
           rd_almost_empty_o, rd_usedw_o, rd_underflow_o
  );

  modport master (
    output rd_req_i, wr_pntr_gray_i,
    input  rd_ack_o, rd_addr_o, rd_pntr_gray_o, rd_empty_o,
           rd_almost_empty_o, rd_usedw_o, rd_underflow_o
  );
endinterface

// File: rtl/rd_side_ctrl_sync.sv
// Read-domain controller for a dual-clock FIFO: synchronises the write gray
// pointer, advances the read pointer on accepted reads, and produces empty,
// almost-empty, used-word count, underflow pulse and the RAM read address.
// Ports:
//   rd_clk_i  read-domain clock (only clock in the block)
//   aclr_n_i  asynchronous active-low reset
//   bus       rd_side_ctrl_sync_if.slave (handshake, pointers, status)
// Parameters:
//   AWIDTH       RAM address width; pointers are AWIDTH+1 bits
//   SYNC_STAGES  flops in the write-pointer synchroniser (>= 2)
//   AE_LEVEL     almost-empty when used words <= AE_LEVEL (0..2**AWIDTH-1)
//   SHOWAHEAD    0 = address of current pointer, 1 = look-ahead address
module rd_side_ctrl_sync #(
  parameter int unsigned AWIDTH      = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_LEVEL    = 1,
  parameter int unsigned SHOWAHEAD   = 0
) (
  input logic             rd_clk_i,
  input logic             aclr_n_i,
  rd_side_ctrl_sync_if.slave bus
);

  localparam int unsigned PW = AWIDTH + 1;

  // Reject illegal parameterisations at elaboration.
  if (AWIDTH < 1) begin : g_bad_awidth
    $error("rd_side_ctrl_sync: AWIDTH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("rd_side_ctrl_sync: SYNC_STAGES must be >= 2");
  end
  if (AE_LEVEL > ((1 << AWIDTH) - 1)) begin : g_bad_ae
    $error("rd_side_ctrl_sync: AE_LEVEL must be in 0..2**AWIDTH-1");
  end
  if (SHOWAHEAD > 1) begin : g_bad_sa
    $error("rd_side_ctrl_sync: SHOWAHEAD must be 0 or 1");
  end

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wr_gray_s;
  logic [PW-1:0] wr_bin;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] rd_bin_next;
  logic [PW-1:0] rd_gray_next;
  logic [PW-1:0] usedw_next;
  logic          rd_ack;

  logic [PW-1:0] rd_gray_q;
  logic          empty_q;
  logic          almost_empty_q;
  logic [PW-1:0] usedw_q;
  logic          underflow_q;

  // Write gray pointer synchroniser chain.
  always_ff @(posedge rd_clk_i or negedge aclr_n_i) begin
    if (!aclr_n_i) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.wr_pntr_gray_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wr_gray_s = sync_q[SYNC_STAGES-1];

  // Gray to binary: each binary bit is the XOR of all gray bits at and above it.
  always_comb begin
    wr_bin = '0;
    for (int i = 0; i < int'(PW); i++) wr_bin[i] = ^(wr_gray_s >> i);
  end

  // Next-state pointer and status terms.
  always_comb begin
    rd_ack       = bus.rd_req_i & ~empty_q;
    rd_bin_next  = rd_bin + PW'(rd_ack);
    rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);
    // Extra MSB makes a full FIFO read 2**AWIDTH rather than 0.
    usedw_next   = wr_bin - rd_bin_next;
  end

  // Read pointer and registered status flags.
  always_ff @(posedge rd_clk_i or negedge aclr_n_i) begin
    if (!aclr_n_i) begin
      rd_bin         <= '0;
      rd_gray_q      <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      usedw_q        <= '0;
      underflow_q    <= 1'b0;
    end else begin
      rd_bin         <= rd_bin_next;
      rd_gray_q      <= rd_gray_next;
      empty_q        <= (rd_gray_next == wr_gray_s);
      almost_empty_q <= (usedw_next <= PW'(AE_LEVEL));
      usedw_q        <= usedw_next;
      underflow_q    <= bus.rd_req_i & empty_q;
    end
  end

  // Show-ahead presents the address of the word that will be at the head
  // after this cycle's read, so RAM output already holds it.
  if (SHOWAHEAD == 1) begin : g_showahead
    assign bus.rd_addr_o = rd_bin_next[AWIDTH-1:0];
  end else begin : g_normal
    assign bus.rd_addr_o = rd_bin[AWIDTH-1:0];
  end

  assign bus.rd_ack_o          = rd_ack;
  assign bus.rd_pntr_gray_o    = rd_gray_q;
  assign bus.rd_empty_o        = empty_q;
  assign bus.rd_almost_empty_o = almost_empty_q;
  assign bus.rd_usedw_o        = usedw_q;
  assign bus.rd_underflow_o    = underflow_q;

endmodule

// File: tb/tb_rd_side_ctrl_sync.sv
// Directed scoreboard bench for rd_side_ctrl_sync (AWIDTH=3, SYNC_STAGES=2,
// AE_LEVEL=1). Two instances share stimulus: normal and show-ahead address.
// Each row gives the inputs applied for one cycle and the outputs expected
// while those inputs are applied (registered state from previous edges plus
// the combinational ack).
module tb_rd_side_ctrl_sync;

  typedef struct packed {
    logic       ack;
    logic [2:0] addr;
    logic [3:0] gray;
    logic       empty;
    logic       ae;
    logic [3:0] usedw;
    logic       uf;
  } obs_t;

  logic rd_clk_i;
  logic aclr_n_i;

  rd_side_ctrl_sync_if #(.AWIDTH(3)) bus_n ();
  rd_side_ctrl_sync_if #(.AWIDTH(3)) bus_s ();

  rd_side_ctrl_sync #(
    .AWIDTH(3), .SYNC_STAGES(2), .AE_LEVEL(1), .SHOWAHEAD(0)
  ) dut_n (
    .rd_clk_i (rd_clk_i),
    .aclr_n_i (aclr_n_i),
    .bus      (bus_n)
  );

  rd_side_ctrl_sync #(
    .AWIDTH(3), .SYNC_STAGES(2), .AE_LEVEL(1), .SHOWAHEAD(1)
  ) dut_s (
    .rd_clk_i (rd_clk_i),
    .aclr_n_i (aclr_n_i),
    .bus      (bus_s)
  );

  obs_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   vec_idx = 0;
  bit   drive_done = 1'b0;

  initial rd_clk_i = 1'b0;
  always #5 rd_clk_i = ~rd_clk_i;

  function automatic obs_t sample_n();
    obs_t o;
    o.ack   = bus_n.rd_ack_o;
    o.addr  = bus_n.rd_addr_o;
    o.gray  = bus_n.rd_pntr_gray_o;
    o.empty = bus_n.rd_empty_o;
    o.ae    = bus_n.rd_almost_empty_o;
    o.usedw = bus_n.rd_usedw_o;
    o.uf    = bus_n.rd_underflow_o;
    return o;
  endfunction

  function automatic obs_t sample_s();
    obs_t o;
    o.ack   = bus_s.rd_ack_o;
    o.addr  = bus_s.rd_addr_o;
    o.gray  = bus_s.rd_pntr_gray_o;
    o.empty = bus_s.rd_empty_o;
    o.ae    = bus_s.rd_almost_empty_o;
    o.usedw = bus_s.rd_usedw_o;
    o.uf    = bus_s.rd_underflow_o;
    return o;
  endfunction

  task automatic compare(input string name, input int idx, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s vec%0d: got ack=%b addr=%0d gray=%b empty=%b ae=%b usedw=%0d uf=%b, expected ack=%b addr=%0d gray=%b empty=%b ae=%b usedw=%0d uf=%b",
               name, idx, got.ack, got.addr, got.gray, got.empty, got.ae, got.usedw, got.uf,
               want.ack, want.addr, want.gray, want.empty, want.ae, want.usedw, want.uf);
    end
  endtask

  // Monitor: pops one expectation per cycle while a vector is being applied.
  always @(negedge rd_clk_i) begin
    if (exp_q.size() > 0) begin
      obs_t e;
      obs_t e_sa;
      e = exp_q.pop_front();
      e_sa = e;
      // Look-ahead address leads the normal one by one on an accepted read.
      e_sa.addr = 3'(e.addr + 3'(e.ack));
      compare("normal", vec_idx, sample_n(), e);
      compare("showahead", vec_idx, sample_s(), e_sa);
      vec_idx++;
    end
  end

  // Driver: apply one vector just after the clock edge and queue its expectation.
  task automatic step(input int rst, input int req, input int wg,
                      input int ack, input int addr, input int gray,
                      input int empty, input int ae, input int usedw, input int uf);
    obs_t e;
    @(posedge rd_clk_i);
    #1;
    aclr_n_i             = 1'(rst);
    bus_n.rd_req_i       = 1'(req);
    bus_s.rd_req_i       = 1'(req);
    bus_n.wr_pntr_gray_i = 4'(wg);
    bus_s.wr_pntr_gray_i = 4'(wg);
    e.ack   = 1'(ack);
    e.addr  = 3'(addr);
    e.gray  = 4'(gray);
    e.empty = 1'(empty);
    e.ae    = 1'(ae);
    e.usedw = 4'(usedw);
    e.uf    = 1'(uf);
    exp_q.push_back(e);
  endtask

  initial begin
    aclr_n_i             = 1'b0;
    bus_n.rd_req_i       = 1'b0;
    bus_s.rd_req_i       = 1'b0;
    bus_n.wr_pntr_gray_i = '0;
    bus_s.wr_pntr_gray_i = '0;

    //    rst req wg       ack addr gray    emp ae usedw uf
    // Reset held with arbitrary inputs.
    step(0, 1, 'b0101,   0, 0, 'b0000,  1, 1, 0, 0);
    step(0, 0, 'b1010,   0, 0, 'b0000,  1, 1, 0, 0);
    step(0, 1, 'b1111,   0, 0, 'b0000,  1, 1, 0, 0);
    step(1, 0, 'b0000,   0, 0, 'b0000,  1, 1, 0, 0);
    // Write pointer 1: empty clears three edges after it is presented.
    step(1, 0, 'b0001,   0, 0, 'b0000,  1, 1, 0, 0);
    step(1, 0, 'b0001,   0, 0, 'b0000,  1, 1, 0, 0);
    step(1, 0, 'b0001,   0, 0, 'b0000,  1, 1, 0, 0);
    step(1, 0, 'b0011,   0, 0, 'b0000,  0, 1, 1, 0);
    step(1, 0, 'b0011,   0, 0, 'b0000,  0, 1, 1, 0);
    step(1, 0, 'b0011,   0, 0, 'b0000,  0, 1, 1, 0);
    // Write pointer 2 visible; move to 8 (full).
    step(1, 0, 'b1100,   0, 0, 'b0000,  0, 0, 2, 0);
    step(1, 0, 'b1100,   0, 0, 'b0000,  0, 0, 2, 0);
    step(1, 0, 'b1100,   0, 0, 'b0000,  0, 0, 2, 0);
    // Full drain: eight reads.
    step(1, 1, 'b1100,   1, 0, 'b0000,  0, 0, 8, 0);
    step(1, 1, 'b1100,   1, 1, 'b0001,  0, 0, 7, 0);
    step(1, 1, 'b1100,   1, 2, 'b0011,  0, 0, 6, 0);
    step(1, 1, 'b1100,   1, 3, 'b0010,  0, 0, 5, 0);
    step(1, 1, 'b1100,   1, 4, 'b0110,  0, 0, 4, 0);
    step(1, 1, 'b1100,   1, 5, 'b0111,  0, 0, 3, 0);
    step(1, 1, 'b1100,   1, 6, 'b0101,  0, 0, 2, 0);
    step(1, 1, 'b1100,   1, 7, 'b0100,  0, 1, 1, 0);
    // Underflow: two requesting cycles while empty.
    step(1, 1, 'b1100,   0, 0, 'b1100,  1, 1, 0, 0);
    step(1, 1, 'b1100,   0, 0, 'b1100,  1, 1, 0, 1);
    step(1, 0, 'b1100,   0, 0, 'b1100,  1, 1, 0, 1);
    // Write pointer to 14, then read 6 to bring rd_bin to 14.
    step(1, 0, 'b1001,   0, 0, 'b1100,  1, 1, 0, 0);
    step(1, 0, 'b1001,   0, 0, 'b1100,  1, 1, 0, 0);
    step(1, 0, 'b1001,   0, 0, 'b1100,  1, 1, 0, 0);
    step(1, 1, 'b1001,   1, 0, 'b1100,  0, 0, 6, 0);
    step(1, 1, 'b1001,   1, 1, 'b1101,  0, 0, 5, 0);
    step(1, 1, 'b1001,   1, 2, 'b1111,  0, 0, 4, 0);
    step(1, 1, 'b1001,   1, 3, 'b1110,  0, 0, 3, 0);
    step(1, 1, 'b1001,   1, 4, 'b1010,  0, 0, 2, 0);
    step(1, 1, 'b1001,   1, 5, 'b1011,  0, 1, 1, 0);
    // Wrapped write pointer (bin 2) against rd_bin 14: four words.
    step(1, 0, 'b0011,   0, 6, 'b1001,  1, 1, 0, 0);
    step(1, 0, 'b0011,   0, 6, 'b1001,  1, 1, 0, 0);
    step(1, 0, 'b0011,   0, 6, 'b1001,  1, 1, 0, 0);
    step(1, 1, 'b0011,   1, 6, 'b1001,  0, 0, 4, 0);
    step(1, 1, 'b0011,   1, 7, 'b1000,  0, 0, 3, 0);
    step(1, 1, 'b0011,   1, 0, 'b0000,  0, 0, 2, 0);
    step(1, 1, 'b0011,   1, 1, 'b0001,  0, 1, 1, 0);
    // Empty after wrap; write pointer to 4 for a mid-read reset.
    step(1, 0, 'b0110,   0, 2, 'b0011,  1, 1, 0, 0);
    step(1, 0, 'b0110,   0, 2, 'b0011,  1, 1, 0, 0);
    step(1, 0, 'b0110,   0, 2, 'b0011,  1, 1, 0, 0);
    step(1, 0, 'b0110,   0, 2, 'b0011,  0, 0, 2, 0);
    step(1, 1, 'b0110,   1, 2, 'b0011,  0, 0, 2, 0);
    // Reset asserted mid-read takes effect before the next edge.
    step(0, 1, 'b0110,   0, 0, 'b0000,  1, 1, 0, 0);
    step(0, 1, 'b0110,   0, 0, 'b0000,  1, 1, 0, 0);
    step(1, 0, 'b0000,   0, 0, 'b0000,  1, 1, 0, 0);
    step(1, 0, 'b0000,   0, 0, 'b0000,  1, 1, 0, 0);
    drive_done = 1'b1;
  end

  // Drain the scoreboard with a bounded wait, then report.
  initial begin
    int budget;
    wait (drive_done);
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge rd_clk_i);
      budget--;
    end
    @(posedge rd_clk_i);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
